// File: rtl/transport_pkg.sv
// Shared header-field constants and parser state encoding for the transport receiver.
package transport_pkg;

    localparam logic [1:0] KIND_CTRL  = 2'b01;
    localparam logic [1:0] KIND_AUDIO = 2'b10;

    localparam int HDR_KIND_HI = 7;
    localparam int HDR_KIND_LO = 6;
    localparam int HDR_CHAN_HI = 3;
    localparam int HDR_CHAN_LO = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CTRL = 2'd1,
        AUD  = 2'd2,
        SKIP = 2'd3
    } pst_t;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO, first-word-fall-through: a write at edge N is poppable at edge N+1.
// No internal backpressure; the writer must check o_free before writing.
module byte_fifo #(
    parameter int DEPTH = 1024,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_wr_vld,
    input  logic [W-1:0]             i_wr_dat,
    input  logic                     i_rd_rdy,
    output logic [W-1:0]             o_rd_dat,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_cnt;
    logic          w_rd;

    assign o_empty  = (r_cnt == '0);
    assign w_rd     = i_rd_rdy && !o_empty;
    assign o_rd_dat = r_mem[r_rptr];
    assign o_free   = (AW+1)'(DEPTH) - r_cnt;

    always_ff @(posedge clk) begin
        if (i_wr_vld) r_mem[r_wptr] <= i_wr_dat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (i_wr_vld) r_wptr <= r_wptr + AW'(1);
            if (w_rd)     r_rptr <= r_rptr + AW'(1);
            r_cnt <= r_cnt + {{AW{1'b0}}, i_wr_vld} - {{AW{1'b0}}, w_rd};
        end
    end

endmodule

// File: rtl/transport_rcv_mux.sv
// Packet receiver: byte FIFO -> header parser -> word assembly -> 1-entry output register.
// Header to out_valid is WORD_B+2 edges; a busy output stalls the parser, ingress never stalls.
module transport_rcv_mux
    import transport_pkg::*;
#(
    parameter int PACKET_BYTES = 16,
    parameter int WORD_W       = 16,
    parameter int FIFO_DEPTH   = 1024,
    parameter int CHANNELS     = 4,
    localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rcv_valid,
    input  logic [7:0]        rcv_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [1:0]        out_kind,
    output logic [CH_W-1:0]   out_chan,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic [15:0]       drop_count,
    output logic [15:0]       overflow_count
);
    localparam int WORD_B = WORD_W / 8;
    localparam int NW     = (PACKET_BYTES - 1) / WORD_B;
    localparam int POS_W  = $clog2(PACKET_BYTES);
    localparam int ACNT_W = $clog2(WORD_B + 1);
    localparam int WIDX_W = $clog2(NW + 1);
    localparam int FREE_W = $clog2(FIFO_DEPTH) + 1;

    logic [POS_W-1:0]  r_pos;
    logic              r_admit;
    logic [FREE_W-1:0] w_free;
    logic              w_pkt_start, w_fits, w_wr;
    logic [7:0]        w_fifo_dat;
    logic              w_empty;

    pst_t              r_state, w_nstate;
    logic [POS_W-1:0]  r_rem, w_rem_n;
    logic [WIDX_W-1:0] r_widx, w_widx_n;
    logic [1:0]        r_kind, w_kind_n;
    logic [CH_W-1:0]   r_chan, w_chan_n;
    logic [WORD_W-1:0] r_asm;
    logic [ACNT_W-1:0] r_acnt, w_acnt_base;
    logic              r_asm_last, w_last_n;
    logic              w_pop, w_take, w_drop, w_word_done;
    logic              w_asm_full, w_out_free, w_xfer, w_stall;
    logic [WORD_W+7:0] w_asm_shift;

    assign w_pkt_start = (r_pos == '0);
    assign w_fits      = (w_free >= FREE_W'(PACKET_BYTES));
    assign w_wr        = rcv_valid && (w_pkt_start ? w_fits : r_admit);

    byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_wr_vld (w_wr),
        .i_wr_dat (rcv_byte),
        .i_rd_rdy (w_pop),
        .o_rd_dat (w_fifo_dat),
        .o_empty  (w_empty),
        .o_free   (w_free)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pos          <= '0;
            r_admit        <= 1'b0;
            overflow_count <= '0;
        end else if (rcv_valid) begin
            r_pos <= (r_pos == POS_W'(PACKET_BYTES - 1)) ? '0 : r_pos + POS_W'(1);
            if (w_pkt_start) r_admit <= w_fits;
            if (w_pkt_start && !w_fits && overflow_count != 16'hFFFF)
                overflow_count <= overflow_count + 16'd1;
        end
    end

    // A complete word waits in the assembly register for one slot in the output register.
    assign w_asm_full  = (r_acnt == ACNT_W'(WORD_B));
    assign w_out_free  = !out_valid || out_ready;
    assign w_xfer      = w_asm_full && w_out_free;
    assign w_stall     = w_asm_full && !w_out_free;
    assign w_acnt_base = w_xfer ? '0 : r_acnt;
    assign w_word_done = ((w_acnt_base + ACNT_W'(1)) == ACNT_W'(WORD_B));
    assign w_take      = w_pop && (r_state == CTRL || r_state == AUD);
    assign w_asm_shift = {r_asm, w_fifo_dat};

    always_comb begin
        w_nstate = r_state;
        w_pop    = 1'b0;
        w_rem_n  = r_rem;
        w_widx_n = r_widx;
        w_kind_n = r_kind;
        w_chan_n = r_chan;
        w_last_n = r_asm_last;
        w_drop   = 1'b0;
        if (!w_empty && !w_stall) begin
            w_pop = 1'b1;
            case (r_state)
                IDLE: begin
                    w_rem_n  = POS_W'(PACKET_BYTES - 1);
                    w_widx_n = '0;
                    if (w_fifo_dat[HDR_KIND_HI:HDR_KIND_LO] == KIND_CTRL) begin
                        w_nstate = CTRL;
                        w_kind_n = KIND_CTRL;
                        w_chan_n = '0;
                    end else if (w_fifo_dat[HDR_KIND_HI:HDR_KIND_LO] == KIND_AUDIO &&
                                 int'(w_fifo_dat[HDR_CHAN_HI:HDR_CHAN_LO]) < CHANNELS) begin
                        w_nstate = AUD;
                        w_kind_n = KIND_AUDIO;
                        w_chan_n = CH_W'(w_fifo_dat[HDR_CHAN_HI:HDR_CHAN_LO]);
                    end else begin
                        w_nstate = SKIP;
                        w_drop   = 1'b1;
                    end
                end
                CTRL: begin
                    w_rem_n = r_rem - POS_W'(1);
                    if (w_word_done) begin
                        w_last_n = 1'b1;
                        w_nstate = (w_rem_n == '0) ? IDLE : SKIP;
                    end
                end
                AUD: begin
                    w_rem_n = r_rem - POS_W'(1);
                    if (w_word_done) begin
                        w_widx_n = r_widx + WIDX_W'(1);
                        w_last_n = (r_widx == WIDX_W'(NW - 1));
                        if (w_last_n) w_nstate = (w_rem_n == '0) ? IDLE : SKIP;
                    end
                end
                default: begin
                    w_rem_n = r_rem - POS_W'(1);
                    if (w_rem_n == '0) w_nstate = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_rem      <= '0;
            r_widx     <= '0;
            r_kind     <= '0;
            r_chan     <= '0;
            r_asm      <= '0;
            r_acnt     <= '0;
            r_asm_last <= 1'b0;
            drop_count <= '0;
        end else begin
            r_state    <= w_nstate;
            r_rem      <= w_rem_n;
            r_widx     <= w_widx_n;
            r_kind     <= w_kind_n;
            r_chan     <= w_chan_n;
            r_asm_last <= w_last_n;
            r_acnt     <= w_take ? w_acnt_base + ACNT_W'(1) : w_acnt_base;
            if (w_take) r_asm <= w_asm_shift[WORD_W-1:0];
            if (w_drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_kind  <= '0;
            out_chan  <= '0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (w_xfer) begin
            out_valid <= 1'b1;
            out_kind  <= r_kind;
            out_chan  <= r_chan;
            out_data  <= r_asm;
            out_last  <= r_asm_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/transport_rcv_mux.md
# transport_rcv_mux

Parametrised packet receiver between the network byte stream and the session layer. Buffers incoming bytes in an internal FIFO, decodes each fixed-length packet's header, and delivers control words and multi-channel audio words to the session layer over a valid/ready handshake. Packets with a bad header, or that cannot fit in the buffer, are dropped whole and counted, so byte alignment is never lost.

## Interface
- PACKET_BYTES, 16, bytes per packet including the 1 header byte; must be ≥ 1 + WORD_W/8
- WORD_W, 16, output word width; must be a multiple of 8 (WORD_B = WORD_W/8)
- FIFO_DEPTH, 1024, byte FIFO depth; power of 2 and ≥ PACKET_BYTES
- CHANNELS, 4, number of audio channels, 1..16 (CH_W = max(1, clog2(CHANNELS)))

- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- rcv_valid  in  1  rcv_byte is valid this cycle; there is no backpressure
- rcv_byte  in  8  network byte
- out_valid  out  1  out_* fields are valid
- out_ready  in  1  session layer accepts the word (not busy)
- out_kind  out  2  01 = control, 10 = audio
- out_chan  out  CH_W  audio channel; 0 for control
- out_data  out  WORD_W  payload word, big-endian (first byte in the MSBs)
- out_last  out  1  last word of the packet
- drop_count  out  16  packets dropped for a bad header; saturates at 0xFFFF
- overflow_count  out  16  packets refused at ingress; saturates at 0xFFFF

## Operation
- Header byte layout: [7:6] = kind; [5:4] reserved and ignored; [3:0] = channel.
- **Ingress.**
  - A byte counter tracks the position within the packet.
  - At a header byte (position 0), the packet is admitted only if FIFO free space ≥ PACKET_BYTES. Otherwise all PACKET_BYTES bytes of that packet are discarded at ingress and overflow_count increments once.
  - Admitted packets are written whole, so the FIFO never sees a full-write.
- **Parser FSM** pops at most 1 byte per cycle. States:
  - IDLE: when the FIFO is non-empty, pop the header.
    - Kind 01 goes to CTRL.
    - Kind 10 with channel < CHANNELS goes to AUD.
    - Anything else goes to SKIP and increments drop_count.
    - rem is set to PACKET_BYTES-1.
  - CTRL: assemble WORD_B bytes into one word with out_last=1, then go to SKIP to discard the remaining rem bytes. If rem = 0, go to IDLE instead.
  - AUD: assemble words continuously. The packet carries NW = floor((PACKET_BYTES-1)/WORD_B) words; the word NW has out_last=1. Then go to SKIP for the (PACKET_BYTES-1) mod WORD_B leftover bytes, or to IDLE if there are none.
  - SKIP: pop and discard until rem = 0, then go to IDLE.
- **Output register (1 entry).**
  - A completed word loads the register when it is empty or being drained in the same cycle. Otherwise the parser stalls, with no pop, until the register frees.
  - The parser keeps popping bytes into the assembly register while a word waits in the output register.
- Both counters saturate at 0xFFFF, never wrap, and are cleared only by reset.

## Timing
- Reset values: out_valid=0, out_kind=0, out_chan=0, out_data=0, out_last=0, both counters 0, FIFO empty, FSM in IDLE, ingress counter 0.
- Reset mid-packet discards all buffered and partial data. The first byte after reset_n deasserts is treated as a header.
- FIFO write latency: a byte written at edge N can be popped at edge N+1.
- Minimum latency, from the header byte sampled at edge 0 to out_valid high, is WORD_B+2 edges. With WORD_B=2 that is edge 4.
- Handshake:
  - A transfer occurs on an edge where out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - out_valid may not depend combinationally on out_ready.
- Throughput with out_ready tied high: 1 byte per cycle sustained, with no bubble between packets.
- A same-cycle ingress write and parser pop are both honoured. Free-space checks use the free count sampled before the edge, which is conservative.

## Structure
- Shared package transport_pkg holds:
  - KIND_CTRL=2'b01 and KIND_AUDIO=2'b10
  - header field bit positions
  - the parser state enum (IDLE, CTRL, AUD, SKIP)
- One sub-module, byte_fifo:
  - parametrised by depth and width 8
  - async active-low reset
  - outputs: empty flag and a free-count (clog2(DEPTH)+1 bits)
  - first-word-fall-through with 1-cycle write-to-read visibility
- All packet logic stays in transport_rcv_mux.

## Test plan
- **Control packet:** defaults; send header 0x40, bytes 0x12, 0x34, then 13 filler bytes, with out_ready=1. Expect one word: kind=01, chan=0, data=0x1234, last=1, out_valid at edge 4. No counters change.
- **Audio packet:** header 0x82, then payload 0x00..0x0E. Expect 7 words 0x0001, 0x0203 … 0x0C0D, all with chan=2 and only the 7th with last=1. Byte 0x0E is discarded.
- **Bad header:** header 0xC0, then a header 0x85 with CHANNELS=4. Expect drop_count=2, no output, and the next valid packet delivered correctly.
- **Backpressure:** hold out_ready=0 for 20 cycles during an audio packet. Expect out_* stable throughout, and no words lost or duplicated once ready rises.
- **Overflow:** FIFO_DEPTH=32, out_ready=0, stream 3 packets. Expect 2 packets buffered, overflow_count=1, and the 4th packet accepted once space frees.
- **Reset mid-packet:** pulse reset_n low after byte 5 of a packet. Expect all outputs at their reset values, then a fresh 0x40 packet delivered normally.
